fifo_traffic_gen: RTL and testbench

Self-checking initiator for the 4-bit FIFO. It drives the FIFO's write and read ports with a deterministic data sequence in phases (fill, drain, stream, flush), respecting `full` and `empty`. It captures `read_data` one cycle after each accepted read, compares it against the regenerated expected sequence, and reports an error count plus a pass/done status. It sits beside the FIFO in block-level benches and in on-chip BIST wrappers.

---
 rtl/fifo_traffic_gen_if.sv | 22 ++
 rtl/fifo_traffic_gen.sv | 223 ++++++++++++++++++++++
 tb/tb_fifo_traffic_gen.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/fifo_traffic_gen_if.sv
// fifo_traffic_gen_if: write/read handshake between the traffic generator
// (master) and the FIFO under test (slave).
interface fifo_traffic_gen_if #(
   parameter int DATA_W = 4
);
   logic              write_en;
   logic [DATA_W-1:0] write_data;
   logic              full;
   logic              read_en;
   logic [DATA_W-1:0] read_data;
   logic              empty;

   modport master (
      output write_en, write_data, read_en,
      input  full, empty, read_data
   );

   modport slave (
      input  write_en, write_data, read_en,
      output full, empty, read_data
   );
endinterface

// File: rtl/fifo_traffic_gen.sv
// fifo_traffic_gen: self-checking initiator for a small FIFO.
// Runs the phases FILL -> DRAIN -> STREAM -> FLUSH -> CHECK -> DONE.
// It writes a regenerated data sequence, compares each read one cycle after
// it is accepted, and reports a saturating mismatch count plus pass/done.
// Optional macro TGEN_LFSR_EN: data comes from a pair of 8-bit LFSRs
// instead of the SEED-masked write/read counters.
module fifo_traffic_gen #(
   parameter int  DATA_W  = 4,
   parameter int  DEPTH   = 4,
   parameter int  NUM_TXN = 16,
   parameter int  SEED    = 0,
   localparam int CNT_W   = $clog2(NUM_TXN + 1)
) (
   input  logic               clk,
   input  logic               rstN,
   input  logic               start,
   fifo_traffic_gen_if.master bus,
   output logic               busy,
   output logic               done,
   output logic               pass,
   output logic [7:0]         err_cnt,
   output logic [CNT_W-1:0]   wr_cnt,
   output logic [CNT_W-1:0]   rd_cnt
);

   localparam logic [CNT_W-1:0] N_C   = CNT_W'(NUM_TXN);
   localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1'b1);

   // Configurations the generator cannot run meaningfully are rejected at elaboration.
   if (NUM_TXN < 1 || DEPTH < 1) begin : g_cfg_err
      $error("fifo_traffic_gen: NUM_TXN and DEPTH must both be at least 1");
   end

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FILL   = 3'd1,
      ST_DRAIN  = 3'd2,
      ST_STREAM = 3'd3,
      ST_FLUSH  = 3'd4,
      ST_CHECK  = 3'd5,
      ST_DONE   = 3'd6
   } state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
   logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
   logic [7:0]        err_q, err_d;
   logic              cmp_vld_q, cmp_vld_d;
   logic [DATA_W-1:0] exp_q, exp_d;

   logic              wr_en_s;
   logic              rd_en_s;
   logic              restart_s;
   logic              wr_room_s;
   logic              rd_avail_s;
   logic [DATA_W-1:0] wr_data_s;
   logic [DATA_W-1:0] exp_now_s;

`ifdef TGEN_LFSR_EN
   localparam logic [7:0] LFSR_INIT_C = 8'h01;

   // The LFSR only supplies 8 bits of data per step.
   if (DATA_W > 8) begin : g_lfsr_w_err
      $error("fifo_traffic_gen: TGEN_LFSR_EN requires DATA_W <= 8");
   end

   logic [7:0] wr_lfsr_q, wr_lfsr_d;
   logic [7:0] exp_lfsr_q, exp_lfsr_d;

   // One step of the 8-bit data LFSR.
   function automatic logic [7:0] lfsr_step(input logic [7:0] v);
      return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
   endfunction

   assign wr_data_s = DATA_W'(wr_lfsr_q);
   assign exp_now_s = DATA_W'(exp_lfsr_q);

   // Write LFSR steps per accepted write, expected LFSR per accepted read.
   always_comb begin
      wr_lfsr_d  = wr_lfsr_q;
      exp_lfsr_d = exp_lfsr_q;
      if (restart_s) begin
         wr_lfsr_d  = LFSR_INIT_C;
         exp_lfsr_d = LFSR_INIT_C;
      end else begin
         wr_lfsr_d  = wr_en_s ? lfsr_step(wr_lfsr_q) : wr_lfsr_q;
         exp_lfsr_d = rd_en_s ? lfsr_step(exp_lfsr_q) : exp_lfsr_q;
      end
   end

   // LFSR state registers.
   always_ff @(posedge clk) begin
      if (!rstN) begin
         wr_lfsr_q  <= LFSR_INIT_C;
         exp_lfsr_q <= LFSR_INIT_C;
      end else begin
         wr_lfsr_q  <= wr_lfsr_d;
         exp_lfsr_q <= exp_lfsr_d;
      end
   end
`else
   localparam logic [DATA_W-1:0] SEED_C = DATA_W'(SEED);

   // Counter mode: the running counts themselves are the data generators.
   assign wr_data_s = DATA_W'(wr_cnt_q) ^ SEED_C;
   assign exp_now_s = DATA_W'(rd_cnt_q) ^ SEED_C;
`endif

   // Phase sequencing and request legality; requests follow full/empty with no delay.
   always_comb begin
      state_d    = state_q;
      wr_en_s    = 1'b0;
      rd_en_s    = 1'b0;
      restart_s  = 1'b0;
      wr_room_s  = !bus.full  && (wr_cnt_q < N_C);
      rd_avail_s = !bus.empty && (rd_cnt_q < N_C);
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d   = ST_FILL;
               restart_s = 1'b1;
            end else begin
               state_d   = state_q;
            end
         end
         ST_FILL: begin
            wr_en_s = wr_room_s;
            if (bus.full || (wr_cnt_q == N_C)) begin
               state_d = ST_DRAIN;
            end else begin
               state_d = ST_FILL;
            end
         end
         ST_DRAIN: begin
            rd_en_s = rd_avail_s;
            if (bus.empty) begin
               state_d = (wr_cnt_q < N_C) ? ST_STREAM : ST_FLUSH;
            end else begin
               state_d = ST_DRAIN;
            end
         end
         ST_STREAM: begin
            wr_en_s = wr_room_s;
            rd_en_s = rd_avail_s;
            if (wr_cnt_q == N_C) begin
               state_d = ST_FLUSH;
            end else begin
               state_d = ST_STREAM;
            end
         end
         ST_FLUSH: begin
            rd_en_s = rd_avail_s;
            if (rd_cnt_q == N_C) begin
               state_d = ST_CHECK;
            end else begin
               state_d = ST_FLUSH;
            end
         end
         ST_CHECK: begin
            state_d = ST_DONE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Counters, compare pipe and the saturating error count.
   always_comb begin
      wr_cnt_d  = wr_cnt_q;
      rd_cnt_d  = rd_cnt_q;
      err_d     = err_q;
      cmp_vld_d = rd_en_s;
      exp_d     = rd_en_s ? exp_now_s : exp_q;
      if (restart_s) begin
         wr_cnt_d  = {CNT_W{1'b0}};
         rd_cnt_d  = {CNT_W{1'b0}};
         err_d     = 8'h00;
         cmp_vld_d = 1'b0;
      end else begin
         wr_cnt_d = wr_en_s ? (wr_cnt_q + ONE_C) : wr_cnt_q;
         rd_cnt_d = rd_en_s ? (rd_cnt_q + ONE_C) : rd_cnt_q;
         if (cmp_vld_q && (bus.read_data != exp_q) && (err_q != 8'hFF)) begin
            err_d = err_q + 8'h01;
         end else begin
            err_d = err_q;
         end
      end
   end

   // State and datapath registers; reset overrides everything, even mid-run.
   always_ff @(posedge clk) begin
      if (!rstN) begin
         state_q   <= ST_IDLE;
         wr_cnt_q  <= {CNT_W{1'b0}};
         rd_cnt_q  <= {CNT_W{1'b0}};
         err_q     <= 8'h00;
         cmp_vld_q <= 1'b0;
         exp_q     <= {DATA_W{1'b0}};
      end else begin
         state_q   <= state_d;
         wr_cnt_q  <= wr_cnt_d;
         rd_cnt_q  <= rd_cnt_d;
         err_q     <= err_d;
         cmp_vld_q <= cmp_vld_d;
         exp_q     <= exp_d;
      end
   end

   assign bus.write_en   = wr_en_s;
   assign bus.write_data = wr_data_s;
   assign bus.read_en    = rd_en_s;

   assign busy    = (state_q == ST_FILL)   || (state_q == ST_DRAIN) ||
                    (state_q == ST_STREAM) || (state_q == ST_FLUSH) ||
                    (state_q == ST_CHECK);
   assign done    = (state_q == ST_DONE);
   assign pass    = done && (err_q == 8'h00);
   assign err_cnt = err_q;
   assign wr_cnt  = wr_cnt_q;
   assign rd_cnt  = rd_cnt_q;

endmodule

// File: tb/tb_fifo_traffic_gen.sv
// tb_fifo_traffic_gen: drives fifo_traffic_gen against a queue-based ideal
// FIFO with optional random stalls and injected read corruption, and scores
// write data, counters and error count against a reference model.
module tb_fifo_traffic_gen;
   localparam int DATA_W  = 4;
   localparam int DEPTH   = 4;
   localparam int NUM_TXN = 16;
   localparam int SEED    = 0;
   localparam int CNT_W   = $clog2(NUM_TXN + 1);

   logic              clk = 1'b0;
   logic              rstN;
   logic              start;
   logic              busy;
   logic              done;
   logic              pass;
   logic [7:0]        err_cnt;
   logic [CNT_W-1:0]  wr_cnt;
   logic [CNT_W-1:0]  rd_cnt;

   fifo_traffic_gen_if #(.DATA_W(DATA_W)) bus_if ();

   fifo_traffic_gen #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .NUM_TXN(NUM_TXN),
      .SEED   (SEED)
   ) dut (
      .clk    (clk),
      .rstN   (rstN),
      .start  (start),
      .bus    (bus_if),
      .busy   (busy),
      .done   (done),
      .pass   (pass),
      .err_cnt(err_cnt),
      .wr_cnt (wr_cnt),
      .rd_cnt (rd_cnt)
   );

   always #5 clk = ~clk;

   int                n_vec = 0;
   int                n_err = 0;
   logic [DATA_W-1:0] fifo_q[$];
   int                n_wr, n_rd, err_model, pend;
   int                bp_left;
   bit                stall_en;
   bit                chk_fill;
   bit                checks_on;
   logic [NUM_TXN-1:0] corrupt_mask;

   // Compare one observed value against its expectation.
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
      end
   endtask

   // k-th value of the generated data sequence of a run.
   function automatic logic [DATA_W-1:0] gen_val(input int k);
`ifdef TGEN_LFSR_EN
      logic [7:0] l;
      l = 8'h01;
      for (int i = 0; i < k; i++) l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
      return l[DATA_W-1:0];
`else
      return DATA_W'(k % (1 << DATA_W)) ^ DATA_W'(SEED);
`endif
   endfunction

   // FIFO status flags: real occupancy plus forced/random stalls.
   task automatic drive_flags();
      bus_if.full  = (fifo_q.size() >= DEPTH) || (bp_left > 0) ||
                     (stall_en && ($urandom_range(0, 3) == 0));
      bus_if.empty = (fifo_q.size() == 0) ||
                     (stall_en && ($urandom_range(0, 3) == 0));
   endtask

   // One clock: check outputs at negedge, then apply the FIFO model after the edge.
   task automatic cycle();
      logic              wr, rd, rst_now;
      logic [DATA_W-1:0] wd, v;
      @(negedge clk);
      rst_now = !rstN;
      wr = bus_if.write_en;
      rd = bus_if.read_en;
      wd = bus_if.write_data;
      if (checks_on) begin
         chk("wr_cnt", 32'(wr_cnt), 32'(n_wr));
         chk("rd_cnt", 32'(rd_cnt), 32'(n_rd));
         chk("err_cnt", 32'(err_cnt), 32'(err_model));
         chk("wr_when_full", 32'(wr && bus_if.full), 32'(0));
         chk("rd_when_empty", 32'(rd && bus_if.empty), 32'(0));
         chk("busy_and_done", 32'(busy && done), 32'(0));
         if (wr) chk("wr_data", 32'(wd), 32'(gen_val(n_wr)));
         if (bp_left > 0) chk("bp_wr_en", 32'(wr), 32'(0));
         if (rd && chk_fill && n_rd == 0) chk("fill_depth", 32'(n_wr), 32'(DEPTH));
      end
      @(posedge clk);
      #1;
      if (rst_now) begin
         fifo_q.delete();
         n_wr = 0; n_rd = 0; err_model = 0; pend = 0;
      end else begin
         if (pend != 0) err_model = (err_model < 255) ? err_model + 1 : 255;
         pend = 0;
         if (rd === 1'b1) begin
            v = fifo_q.pop_front();
            if (n_rd < NUM_TXN && corrupt_mask[n_rd]) begin
               v[0] = ~v[0];
               pend = 1;
            end
            bus_if.read_data = v;
            n_rd++;
         end
         if (wr === 1'b1) begin
            fifo_q.push_back(wd);
            n_wr++;
         end
      end
      if (bp_left > 0) bp_left--;
      drive_flags();
   endtask

   // One complete run from a start pulse to done, then final checks.
   task automatic run(input string name, input bit stall, input logic [NUM_TXN-1:0] mask,
                      input bit bp, input bit mid_rst, input bit fill_chk);
      int cyc;
      bit bp_done, rst_pending;
      stall_en = stall; corrupt_mask = mask; chk_fill = fill_chk;
      bp_done = 1'b0; rst_pending = mid_rst;
      start = 1'b1;
      cycle();
      start = 1'b0;
      n_wr = 0; n_rd = 0; err_model = 0; pend = 0;
      cyc = 0;
      while (!done && cyc < 2000) begin
         if (bp && !bp_done && n_wr == 2) begin
            bp_left = 10; bp_done = 1'b1;
            drive_flags();
         end
         if (rst_pending && n_wr == 7) begin
            rst_pending = 1'b0;
            rstN = 1'b0;
            cycle();
            rstN = 1'b1;
            chk("mrst_busy", 32'(busy), 32'(0));
            chk("mrst_done", 32'(done), 32'(0));
            chk("mrst_wr_en", 32'(bus_if.write_en), 32'(0));
            chk("mrst_rd_en", 32'(bus_if.read_en), 32'(0));
            chk("mrst_wr_cnt", 32'(wr_cnt), 32'(0));
            chk("mrst_rd_cnt", 32'(rd_cnt), 32'(0));
            chk("mrst_err", 32'(err_cnt), 32'(0));
            start = 1'b1;
            cycle();
            start = 1'b0;
         end
         cycle();
         cyc++;
      end
      $display("run %s finished after %0d cycles", name, cyc);
      chk({name, "_done"}, 32'(done), 32'(1));
      chk({name, "_pass"}, 32'(pass), 32'(mask == '0));
      chk({name, "_err"}, 32'(err_cnt), 32'($countones(mask)));
      chk({name, "_wr_cnt"}, 32'(wr_cnt), 32'(NUM_TXN));
      chk({name, "_rd_cnt"}, 32'(rd_cnt), 32'(NUM_TXN));
      chk({name, "_busy"}, 32'(busy), 32'(0));
      chk({name, "_fifo_left"}, 32'(fifo_q.size()), 32'(0));
   endtask

   initial begin
      logic [NUM_TXN-1:0] m;
      checks_on = 1'b0;
      bp_left = 0; stall_en = 1'b0; chk_fill = 1'b0; corrupt_mask = '0;
      n_wr = 0; n_rd = 0; err_model = 0; pend = 0;
      bus_if.read_data = '0;
      rstN = 1'b0; start = 1'b1;
      drive_flags();
      cycle();
      checks_on = 1'b1;
      cycle();
      chk("rst_wr_en", 32'(bus_if.write_en), 32'(0));
      chk("rst_rd_en", 32'(bus_if.read_en), 32'(0));
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_done", 32'(done), 32'(0));
      chk("rst_pass", 32'(pass), 32'(0));
      chk("rst_err", 32'(err_cnt), 32'(0));
      start = 1'b0; rstN = 1'b1;
      cycle();
      chk("idle_busy", 32'(busy), 32'(0));
      chk("idle_wr_en", 32'(bus_if.write_en), 32'(0));

      run("nominal", 1'b0, '0, 1'b0, 1'b0, 1'b1);
      m = '0; m[2] = 1'b1;
      run("corrupt3", 1'b0, m, 1'b0, 1'b0, 1'b1);
      run("backpressure", 1'b0, '0, 1'b1, 1'b0, 1'b0);
      run("mid_reset", 1'b0, '0, 1'b0, 1'b1, 1'b0);
      for (int r = 0; r < 4; r++) begin
         m = NUM_TXN'($urandom & $urandom & $urandom);
         run("random", 1'b1, m, 1'b0, 1'b0, 1'b0);
      end
      run("random_clean", 1'b1, '0, 1'b0, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
